// File: rtl/multi_chan_macc_filter_if.sv
// multi_chan_macc_filter_if: coefficient, sample and result signals of the multi-channel MAC filter
interface multi_chan_macc_filter_if #(
  parameter int DATA_W   = 18,
  parameter int COEFF_W  = 18,
  parameter int TAPS     = 16,
  parameter int CHANNELS = 4
);
  localparam int TW = $clog2(TAPS);
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  logic                      CoeffWr_i;
  logic [TW-1:0]             CoeffAddr_i;
  logic signed [COEFF_W-1:0] CoeffData_i;
  logic signed [DATA_W-1:0]  Data_i;
  logic [CW-1:0]             ChanIdx_i;
  logic                      DataNd_i;
  logic                      Busy_o;
  logic                      Overrun_o;
  logic signed [DATA_W-1:0]  Data_o;
  logic [CW-1:0]             ChanIdx_o;
  logic                      Sat_o;
  logic                      DataValid_o;
  modport slave (
    input  CoeffWr_i, CoeffAddr_i, CoeffData_i, Data_i, ChanIdx_i, DataNd_i,
    output Busy_o, Overrun_o, Data_o, ChanIdx_o, Sat_o, DataValid_o
  );
  modport master (
    output CoeffWr_i, CoeffAddr_i, CoeffData_i, Data_i, ChanIdx_i, DataNd_i,
    input  Busy_o, Overrun_o, Data_o, ChanIdx_o, Sat_o, DataValid_o
  );
endinterface

// File: rtl/multi_chan_macc_filter.sv
// multi_chan_macc_filter: time-multiplexed multi-channel FIR, one shared multiplier and coefficient set
module multi_chan_macc_filter #(
  parameter int DATA_W    = 18,
  parameter int COEFF_W   = 18,
  parameter int TAPS      = 16,
  parameter int CHANNELS  = 4,
  parameter int OUT_SHIFT = 17
) (
  input logic                      Clk_i,
  input logic                      RstN_i,
  multi_chan_macc_filter_if.slave  bus
);
  localparam int TW = $clog2(TAPS);
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int AW = $clog2(CHANNELS * TAPS);
  localparam int PW = DATA_W + COEFF_W;
  localparam int AC = PW + TW;
  localparam logic [2:0] INIT = 3'd0, IDLE = 3'd1, MAC = 3'd2, DRAIN = 3'd3, OUT = 3'd4;
  localparam logic signed [AC:0] MAXV = {{(AC + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [AC:0] MINV = {{(AC + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};
  localparam logic signed [AC:0] HALF = (AC + 1)'(1) << (OUT_SHIFT - 1);
  logic [2:0]                state_q, state_d;
  logic [AW-1:0]             cnt_q, cnt_d;
  logic [TW-1:0]             wp_q [CHANNELS];
  logic [TW-1:0]             base_q, tap;
  logic [CW-1:0]             chan_q, chan_in, cout_q;
  logic signed [DATA_W-1:0]  line_mem [CHANNELS*TAPS];
  logic signed [COEFF_W-1:0] coeff_mem [TAPS];
  logic signed [DATA_W-1:0]  x_q, dout_q, res;
  logic signed [COEFF_W-1:0] h_q;
  logic signed [PW-1:0]      prod_q;
  logic signed [AC-1:0]      acc_q;
  logic signed [AC:0]        rnd, shifted;
  logic [AW-1:0]             rd_addr, wr_addr;
  logic                      rd_v_q, pr_v_q, ovr_q, dv_q, sat_q, accept, hi, lo;
  // cnt_q is the INIT clear address, the MAC tap index and the DRAIN flush count
  always_comb begin
    accept  = bus.DataNd_i && state_q == IDLE;
    chan_in = CHANNELS == 1 ? '0 : bus.ChanIdx_i;
    tap     = cnt_q[TW-1:0];
    rd_addr = AW'({chan_q, TW'(base_q - tap)});
    wr_addr = state_q == INIT ? cnt_q : AW'({chan_in, wp_q[chan_in]});
    state_d = state_q == INIT  ? (&cnt_q ? IDLE : INIT)
            : state_q == IDLE  ? (bus.DataNd_i ? MAC : IDLE)
            : state_q == MAC   ? (&tap ? DRAIN : MAC)
            : state_q == DRAIN ? (cnt_q == AW'(2) ? OUT : DRAIN)
            : IDLE;
    cnt_d   = (state_q == IDLE || state_d != state_q) ? '0 : cnt_q + AW'(1);
    rnd     = {acc_q[AC-1], acc_q} + HALF;
    shifted = rnd >>> OUT_SHIFT;
    hi      = shifted > MAXV;
    lo      = shifted < MINV;
    res     = hi ? MAXV[DATA_W-1:0] : lo ? MINV[DATA_W-1:0] : shifted[DATA_W-1:0];
  end
  // storage and the read/multiply pipeline are left unreset; only the valid flags gate their use
  always_ff @(posedge Clk_i) begin
    if (bus.CoeffWr_i) coeff_mem[bus.CoeffAddr_i] <= bus.CoeffData_i;
    if (state_q == INIT || accept) line_mem[wr_addr] <= state_q == INIT ? '0 : bus.Data_i;
    x_q    <= line_mem[rd_addr];
    h_q    <= coeff_mem[tap];
    prod_q <= PW'(x_q) * PW'(h_q);
  end
  always_ff @(posedge Clk_i or negedge RstN_i) begin
    if (!RstN_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
      base_q  <= '0;
      chan_q  <= '0;
      acc_q   <= '0;
      rd_v_q  <= 1'b0;
      pr_v_q  <= 1'b0;
      ovr_q   <= 1'b0;
      dv_q    <= 1'b0;
      sat_q   <= 1'b0;
      dout_q  <= '0;
      cout_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) wp_q[c] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_v_q  <= state_q == MAC;
      pr_v_q  <= rd_v_q;
      ovr_q   <= bus.DataNd_i && state_q != IDLE;
      dv_q    <= state_q == OUT;
      if (accept) begin
        wp_q[chan_in] <= wp_q[chan_in] + TW'(1);
        base_q        <= wp_q[chan_in];
        chan_q        <= chan_in;
        acc_q         <= '0;
      end else if (pr_v_q) begin
        acc_q <= acc_q + AC'(prod_q);
      end
      if (state_q == OUT) begin
        dout_q <= res;
        cout_q <= chan_q;
        sat_q  <= hi | lo;
      end
    end
  end
  assign bus.Busy_o      = state_q != IDLE;
  assign bus.Overrun_o   = ovr_q;
  assign bus.Data_o      = dout_q;
  assign bus.ChanIdx_o   = cout_q;
  assign bus.Sat_o       = sat_q;
  assign bus.DataValid_o = dv_q;
endmodule

// File: tb/tb_multi_chan_macc_filter.sv
// tb_multi_chan_macc_filter: directed impulse, isolation, overrun, reset-abort and saturation vectors
module tb_multi_chan_macc_filter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [17:0] dout;
  always #5 clk = ~clk;
  multi_chan_macc_filter_if #(.DATA_W(18), .COEFF_W(18), .TAPS(16), .CHANNELS(4)) bus ();
  multi_chan_macc_filter #(.DATA_W(18), .COEFF_W(18), .TAPS(16), .CHANNELS(4), .OUT_SHIFT(17)) dut (
    .Clk_i (clk),
    .RstN_i(rst_n),
    .bus   (bus)
  );
  assign dout = bus.Data_o;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic load_coeffs(input bit all_max);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.CoeffWr_i   = 1'b1;
      bus.CoeffAddr_i = 4'(i);
      bus.CoeffData_i = all_max ? 18'h1FFFF : 18'((i + 1) * 32'h1000);
    end
    @(negedge clk);
    bus.CoeffWr_i = 1'b0;
  endtask
  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (bus.Busy_o && k < 300) begin
      @(negedge clk);
      k++;
    end
  endtask
  task automatic send(input int ch, input logic [17:0] v, output int lat);
    lat = 0;
    wait_idle();
    if (bus.Busy_o) return;
    bus.Data_i    = v;
    bus.ChanIdx_i = 2'(ch);
    bus.DataNd_i  = 1'b1;
    @(posedge clk);
    #1 bus.DataNd_i = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.DataValid_o) begin
        lat = i;
        break;
      end
    end
  endtask
  task automatic txn(input int ch, input logic [17:0] v, input logic [17:0] exp,
                     input logic esat, input bit chk, input string tag);
    int lat;
    send(ch, v, lat);
    if (chk) begin
      check({tag, "_lat"}, lat, 20);
      check(tag, dout, exp);
      check({tag, "_ch"}, bus.ChanIdx_o, ch);
      check({tag, "_sat"}, bus.Sat_o, esat);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
  initial begin
    int cnt, lat;
    logic dv_bad;
    bus.CoeffWr_i = 0; bus.CoeffAddr_i = 0; bus.CoeffData_i = 0;
    bus.Data_i = 0; bus.ChanIdx_i = 0; bus.DataNd_i = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.Busy_o, 1);
    check("rst_valid", bus.DataValid_o, 0);
    check("rst_data", dout, 0);
    check("rst_ovr", bus.Overrun_o, 0);
    rst_n = 1'b1;
    // coefficients are written while INIT keeps the filter busy
    load_coeffs(1'b0);
    @(negedge clk);
    bus.Data_i = 18'h1FFFF; bus.ChanIdx_i = 0; bus.DataNd_i = 1'b1;
    @(posedge clk);
    #1 bus.DataNd_i = 1'b0;
    check("init_ovr", bus.Overrun_o, 1);
    check("init_busy", bus.Busy_o, 1);
    @(posedge clk);
    #1 check("init_ovr_end", bus.Overrun_o, 0);
    for (int k = 0; k < 16; k++)
      txn(0, k == 0 ? 18'h1FFFF : 18'h0, 18'((k + 1) * 32'h1000), 0, 1, $sformatf("imp%0d", k));
    txn(0, 18'h0, 18'h0, 0, 1, "imp16");
    for (int r = 0; r < 17; r++)
      for (int c = 0; c < 4; c++)
        txn(c, (c == 1 && r == 0) ? 18'h1FFFF : 18'h0,
            (c == 1 && r < 16) ? 18'((r + 1) * 32'h1000) : 18'h0, 0, 1, $sformatf("iso_r%0d_c%0d", r, c));
    // overrun: a second sample five cycles after acceptance must be dropped
    wait_idle();
    bus.Data_i = 18'h1FFFF; bus.ChanIdx_i = 2; bus.DataNd_i = 1'b1;
    @(posedge clk);
    #1 bus.DataNd_i = 1'b0;
    check("acc_busy", bus.Busy_o, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.Data_i = 18'h1FFFF; bus.ChanIdx_i = 2; bus.DataNd_i = 1'b1;
    @(posedge clk);
    #1 bus.DataNd_i = 1'b0;
    check("ovr_pulse", bus.Overrun_o, 1);
    @(posedge clk);
    #1 check("ovr_once", bus.Overrun_o, 0);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.DataValid_o) begin
        lat = i + 6;
        break;
      end
    end
    check("ovr_lat", lat, 20);
    check("ovr_data", dout, 18'h1000);
    repeat (5) @(posedge clk);
    #1;
    check("hold_valid", bus.DataValid_o, 0);
    check("hold_data", dout, 18'h1000);
    check("hold_ch", bus.ChanIdx_o, 2);
    txn(2, 18'h0, 18'h2000, 0, 1, "ovr_next");
    // reset in the middle of a MAC on channel 3
    wait_idle();
    bus.Data_i = 18'h1FFFF; bus.ChanIdx_i = 3; bus.DataNd_i = 1'b1;
    @(posedge clk);
    #1 bus.DataNd_i = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", bus.Busy_o, 1);
    check("abort_valid", bus.DataValid_o, 0);
    check("abort_data", dout, 0);
    check("abort_ch", bus.ChanIdx_o, 0);
    check("abort_sat", bus.Sat_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    dv_bad = 1'b0;
    while (bus.Busy_o && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
      if (bus.DataValid_o) dv_bad = 1'b1;
    end
    check("abort_busy_cycles", cnt, 64);
    check("abort_no_valid", dv_bad, 0);
    txn(0, 18'h1FFFF, 18'h1000, 0, 1, "post_rst0");
    txn(0, 18'h0, 18'h2000, 0, 1, "post_rst1");
    txn(0, 18'h0, 18'h3000, 0, 1, "post_rst2");
    load_coeffs(1'b1);
    for (int k = 0; k < 16; k++) txn(0, 18'h1FFFF, 18'h1FFFF, 1, k == 15, "sat_pos");
    for (int k = 0; k < 16; k++) txn(0, 18'h20000, 18'h20000, 1, k == 15, "sat_neg");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_chan_macc_filter.md
MULTI_CHAN_MACC_FILTER -- requirements
Module: multi_chan_macc_filter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  DATA_W 18 sample/output width, signed two's complement
  COEFF_W 18 coefficient width, signed
  TAPS 16 taps per channel, power of two, 4..256
  CHANNELS 4 independent channels, power of two, 1..16
  OUT_SHIFT 17 accumulator right shift before rounding, 1..COEFF_W+clog2(TAPS)
REQ-002 Ports (name, direction, width, meaning):
  Clk_i in 1 sole clock, all logic rising-edge
  RstN_i in 1 reset, asynchronous, active-low
  CoeffWr_i in 1 coefficient write strobe
  CoeffAddr_i in clog2(TAPS) tap index written
  CoeffData_i in COEFF_W coefficient value
  Data_i in DATA_W input sample
  ChanIdx_i in max(1,clog2(CHANNELS)) channel of Data_i
  DataNd_i in 1 new-data strobe, one cycle per sample
  Busy_o out 1 high = DataNd_i will not be accepted
  Overrun_o out 1 one-cycle pulse: DataNd_i dropped
  Data_o out DATA_W filter output
  ChanIdx_o out max(1,clog2(CHANNELS)) channel of Data_o
  Sat_o out 1 Data_o was saturated
  DataValid_o out 1 one-cycle output strobe

Function
REQ-003 One coefficient set of TAPS entries is shared by all channels; each channel has its own circular delay line of TAPS samples.
REQ-004 A CoeffWr_i write is visible to tap reads from the following cycle; writes are accepted in every state, including while Busy_o is high.
REQ-005 States: INIT (delay-line clear), IDLE, MAC, DRAIN, OUT.
REQ-006 INIT: entered on reset release; writes zero to all CHANNELS*TAPS delay-line words, one per cycle; Busy_o high throughout; then IDLE.
REQ-007 IDLE: DataNd_i=1 accepts the sample: writes Data_i at the channel's write pointer, advances that pointer (wraps TAPS-1 -> 0), latches ChanIdx_i, clears the accumulator, enters MAC.
REQ-008 MAC: exactly TAPS cycles; cycle i reads x[n-i] and h[i]; one multiply-accumulate per cycle through a single multiplier.
REQ-009 DRAIN covers pipeline flush; OUT presents the result.
REQ-010 DataValid_o is high for exactly one cycle, TAPS+4 cycles after the edge that sampled the accepted DataNd_i.
REQ-011 Busy_o rises the cycle after acceptance and falls on the edge DataValid_o rises; a DataNd_i in the DataValid_o cycle is accepted.
REQ-012 DataNd_i while Busy_o=1 (INIT included): sample discarded, no state change, Overrun_o high the next cycle for one cycle.
REQ-013 Product width DATA_W+COEFF_W; accumulator width DATA_W+COEFF_W+clog2(TAPS); no internal overflow possible.
REQ-014 Output = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (round half-up), then saturate to DATA_W signed range; Sat_o=1 when clipping occurred.
REQ-015 Data_o, ChanIdx_o, Sat_o are updated only with DataValid_o and hold their value otherwise.
REQ-016 ChanIdx_i >= CHANNELS is treated as ChanIdx_i mod CHANNELS.

Reset
REQ-017 RstN_i=0 at any time, mid-MAC included, aborts the computation immediately: DataValid_o=0, Overrun_o=0, Sat_o=0, Data_o=0, ChanIdx_o=0, Busy_o=1, all write pointers=0, state INIT.
REQ-018 Coefficients are not cleared by reset; delay lines are zeroed by INIT; no output is produced for a computation aborted by reset.

Verification
REQ-019 Impulse: TAPS=16, h[i]=(i+1)*0x1000, ch0 gets 0x1FFFF followed by zeros every 32 cycles -> 16 outputs 0x01000, 0x02000, ..., 0x10000, then 0; Sat_o=0; each DataValid_o exactly 20 cycles after its DataNd_i.
REQ-020 Channel isolation: impulse on ch1, zeros on ch0/2/3 interleaved -> only ChanIdx_o=1 outputs are non-zero, matching REQ-019.
REQ-021 Saturation: all h=0x1FFFF, constant input 0x1FFFF -> Data_o=0x1FFFF, Sat_o=1 once the line is full; constant input 0x20000 -> Data_o=0x20000, Sat_o=1.
REQ-022 Overrun: DataNd_i 5 cycles after an accepted sample -> Overrun_o pulses once; the dropped sample never affects any output.
REQ-023 Reset mid-MAC: RstN_i low for 2 cycles 8 cycles after acceptance -> no DataValid_o; Busy_o high for exactly 64 cycles after release; the next impulse reproduces REQ-019 with the coefficients retained.
